// File: rtl/alu_operand_stage_pkg.sv
// Shared operand-select encodings and default widths for the ALU operand stage.
package alu_operand_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RAW_DEF  = 5;

  localparam logic [2:0] OPSEL_RR = 3'b000;
  localparam logic [2:0] OPSEL_RI = 3'b001;
  localparam logic [2:0] OPSEL_PI = 3'b010;
  localparam logic [2:0] OPSEL_RP = 3'b011;
  localparam logic [2:0] OPSEL_ZI = 3'b100;
  localparam logic [2:0] OPSEL_P4 = 3'b101;

  function automatic logic sel_reserved(input logic [2:0] s);
    return (s == 3'b110) || (s == 3'b111);
  endfunction

endpackage

// File: rtl/fwd_resolve.sv
// Priority match of one source register against the forwarding sources.
// The lowest index (youngest) wins; x0 is never forwarded.
module fwd_resolve #(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  parameter int RAW  = 5
) (
  input  logic [RAW-1:0]       addr,
  input  logic [XLEN-1:0]      data,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RAW-1:0]  fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]      res
);

  always_comb begin
    res = data;
    // Walk oldest to youngest so the youngest match overrides.
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (addr != '0 && fwd_valid[k] &&
          fwd_addr[k*RAW +: RAW] == addr)
        res = fwd_data[k*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand select with forwarding and valid/ready output register.
// Define SKID_EN for a one-entry skid buffer and a registered in_ready.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NFWD = 2,
  parameter int RAW  = RAW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           sel,
  input  logic [RAW-1:0]       rs1_addr,
  input  logic [RAW-1:0]       rs2_addr,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      imm,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RAW-1:0]  fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      alu_in1,
  output logic [XLEN-1:0]      alu_in2,
  output logic                 illegal_sel
);

  logic [XLEN-1:0] r1;
  logic [XLEN-1:0] r2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            ill;
  logic            accept;
  logic            xfer;

  fwd_resolve #(
    .XLEN(XLEN), .NFWD(NFWD), .RAW(RAW)
  ) u_fwd1 (
    .addr      (rs1_addr),
    .data      (rs1_data),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .res       (r1)
  );

  fwd_resolve #(
    .XLEN(XLEN), .NFWD(NFWD), .RAW(RAW)
  ) u_fwd2 (
    .addr      (rs2_addr),
    .data      (rs2_data),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .res       (r2)
  );

  always_comb begin
    op1 = r1;
    op2 = r2;
    ill = sel_reserved(sel);
    unique case (sel)
      OPSEL_RR: begin
        op1 = r1;
        op2 = r2;
      end
      OPSEL_RI: begin
        op1 = r1;
        op2 = imm;
      end
      OPSEL_PI: begin
        op1 = pc;
        op2 = imm;
      end
      OPSEL_RP: begin
        op1 = r1;
        op2 = pc;
      end
      OPSEL_ZI: begin
        op1 = '0;
        op2 = imm;
      end
      OPSEL_P4: begin
        op1 = pc;
        op2 = XLEN'(4);
      end
      default: begin
        op1 = r1;
        op2 = r2;
      end
    endcase
  end

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

`ifdef SKID_EN
  logic            skid_full;
  logic [XLEN-1:0] skid_in1;
  logic [XLEN-1:0] skid_in2;
  logic            skid_ill;

  assign in_ready = !skid_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      illegal_sel <= 1'b0;
      skid_full   <= 1'b0;
      skid_in1    <= '0;
      skid_in2    <= '0;
      skid_ill    <= 1'b0;
    end else if (skid_full) begin
      if (xfer) begin
        alu_in1     <= skid_in1;
        alu_in2     <= skid_in2;
        illegal_sel <= skid_ill;
        skid_full   <= 1'b0;
      end
    end else if (out_valid && !out_ready) begin
      // Output stalled: park the new item behind it.
      if (accept) begin
        skid_in1  <= op1;
        skid_in2  <= op2;
        skid_ill  <= ill;
        skid_full <= 1'b1;
      end
    end else if (accept) begin
      alu_in1     <= op1;
      alu_in2     <= op2;
      illegal_sel <= ill;
      out_valid   <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      illegal_sel <= 1'b0;
    end else if (accept) begin
      alu_in1     <= op1;
      alu_in2     <= op2;
      illegal_sel <= ill;
      out_valid   <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised bench for alu_operand_stage against a FIFO-based reference model.
// Define SKID_EN here as well when building the skid variant.
module tb_alu_operand_stage;

  localparam int XLEN = 32;
  localparam int NFWD = 2;
  localparam int RAW  = 5;

  typedef struct {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            ill;
  } item_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           sel;
  logic [RAW-1:0]       rs1_addr;
  logic [RAW-1:0]       rs2_addr;
  logic [XLEN-1:0]      rs1_data;
  logic [XLEN-1:0]      rs2_data;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      imm;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD*RAW-1:0]  fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      alu_in1;
  logic [XLEN-1:0]      alu_in2;
  logic                 illegal_sel;

  int    errors = 0;
  int    checks = 0;
  item_t q[$];

  alu_operand_stage #(
    .XLEN(XLEN), .NFWD(NFWD), .RAW(RAW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel         (sel),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .pc          (pc),
    .imm         (imm),
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .illegal_sel (illegal_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] resolve(input logic [RAW-1:0] a,
                                              input logic [XLEN-1:0] d);
    if (a == 0) return d;
    for (int k = 0; k < NFWD; k++)
      if (fwd_valid[k] && fwd_addr[k*RAW +: RAW] == a)
        return fwd_data[k*XLEN +: XLEN];
    return d;
  endfunction

  function automatic item_t model_item();
    item_t it;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    r1 = resolve(rs1_addr, rs1_data);
    r2 = resolve(rs2_addr, rs2_data);
    it.ill = 1'b0;
    case (sel)
      3'd0: begin it.a = r1; it.b = r2;  end
      3'd1: begin it.a = r1; it.b = imm; end
      3'd2: begin it.a = pc; it.b = imm; end
      3'd3: begin it.a = r1; it.b = pc;  end
      3'd4: begin it.a = 0;  it.b = imm; end
      3'd5: begin it.a = pc; it.b = 4;   end
      default: begin it.a = r1; it.b = r2; it.ill = 1'b1; end
    endcase
    return it;
  endfunction

  function automatic logic model_ready();
`ifdef SKID_EN
    return q.size() < 2;
`else
    return q.size() == 0 || out_ready;
`endif
  endfunction

  // Caller drives inputs just after a falling edge, then calls step.
  task automatic step();
    item_t it;
    logic  rdy;
    logic  acc;
    logic  xf;
    #1;
    rdy = model_ready();
    check("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    xf  = (q.size() > 0) && out_ready;
    it  = model_item();
    if (xf) void'(q.pop_front());
    if (acc) q.push_back(it);
    @(posedge clk);
    @(negedge clk);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("alu_in1", alu_in1, q[0].a);
      check("alu_in2", alu_in2, q[0].b);
      check("illegal_sel", illegal_sel, q[0].ill);
    end
  endtask

  task automatic rand_inputs();
    sel       = 3'($urandom_range(0, 7));
    rs1_addr  = RAW'($urandom_range(0, 3));
    rs2_addr  = RAW'($urandom_range(0, 3));
    rs1_data  = $urandom;
    rs2_data  = $urandom;
    pc        = $urandom;
    imm       = $urandom;
    fwd_valid = NFWD'($urandom);
    for (int k = 0; k < NFWD; k++) begin
      fwd_addr[k*RAW +: RAW]   = RAW'($urandom_range(0, 3));
      fwd_data[k*XLEN +: XLEN] = $urandom;
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rand_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_alu_in2", alu_in2, 0);
    check("rst_illegal", illegal_sel, 0);

    sel = 3'b010; pc = 32'h100; imm = 32'h20; in_valid = 1'b1;
    rst_n = 1'b1;
    step();
    check("pi_in1", alu_in1, 32'h100);
    check("pi_in2", alu_in2, 32'h20);

    sel = 3'b000; rs1_addr = 5; rs1_data = 32'h11;
    rs2_addr = 7; rs2_data = 32'h77;
    fwd_valid = 2'b11;
    fwd_addr = {5'd5, 5'd5};
    fwd_data = {32'hBB, 32'hAA};
    step();
    check("fwd_youngest", alu_in1, 32'hAA);
    rs1_addr = 0; fwd_addr = {5'd0, 5'd0};
    step();
    check("fwd_x0", alu_in1, 32'h11);

    sel = 3'b101; pc = 32'h2000;
    step();
    check("p4_in1", alu_in1, 32'h2000);
    check("p4_in2", alu_in2, 32'h4);
    sel = 3'b100; imm = 32'h12345000;
    step();
    check("lui_in1", alu_in1, 32'h0);
    check("lui_in2", alu_in2, 32'h12345000);

    sel = 3'b111; rs1_addr = 3; rs2_addr = 4; fwd_valid = 0;
    rs1_data = 32'hCAFE; rs2_data = 32'hBEEF;
    step();
    check("rsv_ill", illegal_sel, 1);
    check("rsv_in1", alu_in1, 32'hCAFE);
    check("rsv_in2", alu_in2, 32'hBEEF);
    sel = 3'b001;
    step();
    check("rsv_clear", illegal_sel, 0);

    // Stall: output held, forwarding changes must not leak into held data.
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    out_ready = 1'b1; in_valid = 1'b1; rand_inputs();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      step();
    end

    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_in1", alu_in1, 0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
